// File: rtl/spi_mem_pkg.sv
// Shared constants, state encoding and frame builder for the SPI memory responder.
// The state encoding is fixed so that debug probes can decode dbg_state directly.
package spi_mem_pkg;

  localparam logic [7:0] SPI_OP_READ  = 8'h03;
  localparam logic [7:0] SPI_OP_WRITE = 8'h02;
  localparam int SPI_FRAME_BITS = 32;

  // SCLK toggle index of the 25th rising edge; the read byte is sampled from here on.
  localparam int SPI_RX_FIRST_EDGE = 48;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    SPI_IDLE  = ST_IDLE,
    SPI_SHIFT = ST_SHIFT,
    SPI_DONE  = ST_DONE
  } spi_state_t;

  function automatic logic [SPI_FRAME_BITS-1:0] spi_frame(input logic rd,
                                                          input logic [15:0] addr,
                                                          input logic [7:0] data);
    return {(rd ? SPI_OP_READ : SPI_OP_WRITE), addr, (rd ? 8'h00 : data)};
  endfunction

endpackage

// File: rtl/spi_memory_responder_if.sv
// CPU-bus and SPI-pad signals of the memory responder, bundled for the port list.
// request is a one-cycle strobe taken when request & ready at a clock edge; writes seen
// with ready=0 are posted to a one-entry slot, reads with ready=0 are dropped and must be
// re-presented; ready=1 also means cpuReadData holds the last completed read byte.
interface spi_memory_responder_if;
  logic       request;
  logic       readNotWrite;
  logic [7:0] addressBusHigh;
  logic [7:0] addressBusLow;
  logic [7:0] cpuWriteData;
  logic [7:0] cpuReadData;
  logic       ready;
  logic       overrun;
  logic       spiSclk;
  logic       spiCsN;
  logic       spiMosi;
  logic       spiMiso;

  modport master (
    output request, readNotWrite, addressBusHigh, addressBusLow, cpuWriteData, spiMiso,
    input  cpuReadData, ready, overrun, spiSclk, spiCsN, spiMosi
  );

  modport slave (
    input  request, readNotWrite, addressBusHigh, addressBusLow, cpuWriteData, spiMiso,
    output cpuReadData, ready, overrun, spiSclk, spiCsN, spiMosi
  );
endinterface

// File: rtl/spi_bit_timer.sv
// SCLK generator: divides clk by CLK_DIV into toggle strobes and counts the 64 SCLK
// edges of one frame. Everything is held cleared while run is low.
module spi_bit_timer import spi_mem_pkg::*; #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       run,
  output logic       toggle,
  output logic       sclk,
  output logic [5:0] edge_cnt,
  output logic       frame_done
);

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [5:0] EDGE_LAST = 6'(2 * SPI_FRAME_BITS - 1);

  logic [7:0] div_cnt;

  assign toggle     = run && (div_cnt == DIV_LAST);
  assign frame_done = toggle && (edge_cnt == EDGE_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
    end else if (!run) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk     <= 1'b0;
    end else if (toggle) begin
      div_cnt  <= '0;
      edge_cnt <= edge_cnt + 6'd1;
      sclk     <= ~sclk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_memory_responder.sv
// CPU bus to SPI SRAM bridge: each bus access becomes one 32-bit SPI frame
// (opcode, address, data). Reads stall the core through ready; writes are posted.
module spi_memory_responder import spi_mem_pkg::*; #(
  parameter int CLK_DIV = 2
) (
  input  logic                   clk,
  input  logic                   nrst,
  spi_memory_responder_if.slave  bus,
  output spi_state_t             dbg_state
);

  spi_state_t state;

  logic                      slot_valid;
  logic [15:0]               slot_addr;
  logic [7:0]                slot_data;
  logic [SPI_FRAME_BITS-1:0] tx;
  logic [7:0]                rx;
  logic                      is_read;
  logic                      cs_n;
  logic [7:0]                read_data;
  logic                      overrun;

  logic       shifting;
  logic       toggle;
  logic       sclk;
  logic [5:0] edge_cnt;
  logic       frame_done;

  logic        ready;
  logic        accept;
  logic        slot_launch;
  logic        slot_write;
  logic [15:0] req_addr;

  assign req_addr    = {bus.addressBusHigh, bus.addressBusLow};
  assign ready       = (state == SPI_IDLE) && !slot_valid;
  assign accept      = bus.request && ready;
  assign slot_launch = (state == SPI_IDLE) && slot_valid;
  assign slot_write  = bus.request && !bus.readNotWrite && !ready;
  assign shifting    = (state == SPI_SHIFT);

  spi_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk        (clk),
    .nrst       (nrst),
    .run        (shifting),
    .toggle     (toggle),
    .sclk       (sclk),
    .edge_cnt   (edge_cnt),
    .frame_done (frame_done)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= SPI_IDLE;
      tx        <= '0;
      rx        <= '0;
      is_read   <= 1'b0;
      cs_n      <= 1'b1;
      read_data <= '0;
    end else begin
      case (state)
        SPI_IDLE: begin
          // A pending posted write always goes out before a new request.
          if (slot_launch) begin
            tx      <= spi_frame(1'b0, slot_addr, slot_data);
            is_read <= 1'b0;
            cs_n    <= 1'b0;
            state   <= SPI_SHIFT;
          end else if (accept) begin
            tx      <= spi_frame(bus.readNotWrite, req_addr, bus.cpuWriteData);
            is_read <= bus.readNotWrite;
            cs_n    <= 1'b0;
            state   <= SPI_SHIFT;
          end
        end
        SPI_SHIFT: begin
          // MOSI advances as SCLK falls, so it is settled well before the next rise.
          if (toggle && sclk) begin
            tx <= {tx[SPI_FRAME_BITS-2:0], 1'b0};
          end
          if (toggle && !sclk && (edge_cnt >= 6'(SPI_RX_FIRST_EDGE))) begin
            rx <= {rx[6:0], bus.spiMiso};
          end
          if (frame_done) begin
            state <= SPI_DONE;
          end
        end
        SPI_DONE: begin
          cs_n  <= 1'b1;
          state <= SPI_IDLE;
          if (is_read) begin
            read_data <= rx;
          end
        end
        default: state <= SPI_IDLE;
      endcase
    end
  end

  // A write landing while the slot is being launched refills it without overrun.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      slot_valid <= 1'b0;
      slot_addr  <= '0;
      slot_data  <= '0;
      overrun    <= 1'b0;
    end else if (slot_write) begin
      if (!slot_valid || slot_launch) begin
        slot_valid <= 1'b1;
        slot_addr  <= req_addr;
        slot_data  <= bus.cpuWriteData;
      end else begin
        overrun <= 1'b1;
      end
    end else if (slot_launch) begin
      slot_valid <= 1'b0;
    end
  end

  assign bus.spiSclk     = sclk;
  assign bus.spiCsN      = cs_n;
  assign bus.spiMosi     = tx[SPI_FRAME_BITS-1];
  assign bus.cpuReadData = read_data;
  assign bus.ready       = ready;
  assign bus.overrun     = overrun;
  assign dbg_state       = state;

endmodule

// File: doc/spi_memory_responder.md
# spi_memory_responder

Bus responder for the CPU core's external memory interface. Accepts read/write requests on the 16-bit address / 8-bit data bus and serves each one as a single-byte SPI transaction to an external 23LC512-class SPI SRAM. It drives `ready` to stall CPU reads until the data has returned. Writes are posted, because the core does not wait on `ready` for writes. The block sits between the CPU core's bus pins and the chip's SPI pads.

## Interface
- `CLK_DIV`, default 2: `clk` cycles per SCLK half-period; legal range 1–255.
- `clk` input, 1 bit: single clock.
- `nrst` input, 1 bit: reset, asynchronous, active-low.
- `request` input, 1 bit: access strobe from the core, one cycle per access.
- `readNotWrite` input, 1 bit: 1 = read, 0 = write; sampled with `request`.
- `addressBusHigh` input, 8 bits: address [15:8].
- `addressBusLow` input, 8 bits: address [7:0].
- `cpuWriteData` input, 8 bits: write data (core's data-bus output).
- `cpuReadData` output, 8 bits: last read byte; feeds the core's data-bus input.
- `ready` output, 1 bit: 1 = idle with no pending work; read data valid.
- `overrun` output, 1 bit: sticky; a write was dropped; cleared only by reset.
- `spiSclk` output, 1 bit: SPI clock, mode 0 (idles low).
- `spiCsN` output, 1 bit: chip select, active-low.
- `spiMosi` output, 1 bit: serial data out.
- `spiMiso` input, 1 bit: serial data in.

## Operation
- States: `IDLE`, `SHIFT`, `DONE`.
- **Acceptance**
  - A request is accepted when `request & ready`. It loads a 32-bit shift frame {opcode, addrHigh, addrLow, data}.
  - Opcode is `8'h03` for a read, `8'h02` for a write. For a read, the data byte is `8'h00`.
- **Posted writes**
  - A write request with `ready=0` goes into a one-entry pending slot, holding address and data.
  - If the slot is already full, the write is dropped and `overrun` is set.
  - A read request with `ready=0` is ignored; the core re-presents it after `ready` rises.
- **IDLE**
  - If the pending slot is full, it is launched first.
  - Otherwise an accepted request is launched.
  - A launch clears `ready` in the next cycle and enters `SHIFT`.
- **SHIFT**
  - `spiCsN`=0. `spiSclk` toggles every `CLK_DIV` cycles, 64 toggles total (32 bits, MSB first).
  - `spiMosi` changes only while `spiSclk` is low and is stable before each rising edge.
  - `spiMiso` is sampled on rising edges 25–32 into the read byte.
  - After the 64th toggle (SCLK low), go to `DONE`.
- **DONE** (one cycle)
  - `spiCsN`=1. For a read, `cpuReadData` is loaded with the sampled byte.
  - Return to `IDLE`. If the slot is full, the next launch follows immediately.
- `cpuReadData` holds its value until the next read completes; writes never change it.
- `ready` = (state==`IDLE`) & slot empty.
- **Reset**, asynchronous, at any point including mid-frame:
  - state `IDLE`, `spiCsN`=1, `spiSclk`=0, `spiMosi`=0, `ready`=1, `cpuReadData`=0, `overrun`=0, slot empty.

## Timing
- Accept at edge N.
  - `spiCsN` falls at N+1.
  - The first SCLK rise occurs at N+1+`CLK_DIV`.
  - The last SCLK fall occurs at N+1+64·`CLK_DIV` (= `DONE`).
  - `spiCsN` rises and `ready` returns at N+2+64·`CLK_DIV`.
- Read latency with `CLK_DIV`=2: 130 cycles from accept to `ready`=1 with valid `cpuReadData`.
- Minimum CS-high time between frames: 1 cycle.
- A request in the same cycle that `ready` rises counts as `ready`=1 and is accepted.
- A write arriving in the `DONE` cycle goes to the slot. If a slot write and a slot launch fall in the same cycle, the launch takes the old entry and the new write fills the slot; no overrun.

## Structure
- Shared package `spi_mem_pkg`:
  - opcode constants `SPI_OP_READ`=8'h03 and `SPI_OP_WRITE`=8'h02
  - state enum `spi_state_t`
  - `SPI_FRAME_BITS`=32
- Sub-module `spi_bit_timer`:
  - `CLK_DIV` counter producing a toggle strobe and the SCLK level
  - 6-bit edge counter with `frameDone`

## Test plan
- **Single read.** Reset, then read 0x1234 with `CLK_DIV`=2 and the model returning 0xA5 → MOSI frame 03 12 34 00; `ready` low for cycles N+1..N+129; `cpuReadData`=0xA5 at N+130.
- **Single write.** Write 0xBEEF ← 0x5A → MOSI frame 02 BE EF 5A; `cpuReadData` unchanged; `ready` returns at N+130.
- **Posted writes while busy.** Write A, then write B 10 cycles later → B is sent back-to-back after A with exactly 1 cycle of CS high. A third write during A → dropped, `overrun`=1, only two frames on the wire.
- **Read ignored while busy.** Read during a write → no extra frame. The re-presented read after `ready` rises is accepted the same cycle.
- **Reset mid-frame.** `nrst` pulsed at bit 17 → outputs take their reset values immediately; the next read completes normally.
- **Divider sweep.** `CLK_DIV`=1 and `CLK_DIV`=5 → SCLK period 2 and 10 cycles; latency 66 and 322 cycles.
